entropy_bit_buffer: RTL
=======================

# entropy_bit_buffer

Collects raw noise-source bits one per valid cycle into a 1024-bit circular buffer and drives `random_bits` and `index_of_last_bit` to the repetition count test that sits directly downstream. The block qualifies that test's `failure` output, latches a sticky alarm, and hands each fresh 1024-bit block to the SHA3 conditioner with a valid/ready handshake. Raw bits that arrive while a block is waiting are dropped and counted.

## Interface
- `BUF_BITS`, 1024, buffer depth in bits; must be a power of two.
- `IDX_W`, 10, index width, log2(BUF_BITS).
- `WARMUP_BITS`, 256, raw bits discarded after reset; used only with the macro.
- `REP_WINDOW`, 22, number of bits the downstream test inspects.
- `clk`  in  1  sole clock; every flop is rising-edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `raw_bit`  in  1  noise-source sample.
- `raw_valid`  in  1  `raw_bit` is valid this cycle.
- `health_fail`  in  1  `failure` from the repetition count test; combinational from this block's outputs.
- `random_bits`  out  BUF_BITS  circular buffer contents.
- `index_of_last_bit`  out  IDX_W  position of the most recently written bit.
- `block_valid`  out  1  BUF_BITS fresh bits are ready for the conditioner.
- `block_ready`  in  1  the conditioner accepts the block.
- `alarm`  out  1  sticky health failure.
- `overrun_cnt`  out  16  count of dropped raw bits; saturates at 16'hFFFF.

## Operation
- States:
  - WARMUP: only with the macro.
  - FILL
  - FULL
  - ALARM
- Reset:
  - `random_bits` = 0
  - `index_of_last_bit` = BUF_BITS-1, so the first write lands at 0.
  - `fill_cnt` (11 bits) = 0
  - `hist_cnt` (5 bits) = 0
  - `overrun_cnt` = 0
  - `alarm` = 0
  - `block_valid` = 0
  - State = FILL, or WARMUP when the macro is defined.
- Write, in FILL with `raw_valid`=1:
  - Next index = (index+1) mod BUF_BITS.
  - `random_bits[next]` <= `raw_bit`.
  - `index_of_last_bit` <= next.
  - `fill_cnt`++.
  - `hist_cnt` increments and saturates at REP_WINDOW.
- FILL → FULL on the write that makes `fill_cnt` = BUF_BITS.
- FULL:
  - The buffer is frozen.
  - Each `raw_valid` increments `overrun_cnt` and the bit is lost.
- Handshake, `block_valid` && `block_ready`:
  - `fill_cnt` <= 0 and the state goes to FILL.
  - A `raw_valid` in that same cycle is dropped and counted as an overrun.
  - `hist_cnt` is kept, because buffer history stays contiguous.
- Qualified failure = `health_fail` && (`hist_cnt` == REP_WINDOW) && state ∈ {FILL, FULL}.
  - On a qualified failure the next state is ALARM and `alarm` <= 1.
- ALARM:
  - Terminal; only reset leaves it.
  - No writes; `raw_valid` is ignored and does not count as an overrun.
- `block_valid` = (state == FULL) && !qualified failure; combinational gating, so a failing block is never offered.
- Width rules:
  - Index arithmetic is IDX_W bits with natural wrap.
  - `fill_cnt` is IDX_W+1 bits.

## Timing
- A write at edge N becomes visible on `random_bits` and `index_of_last_bit` after edge N. `health_fail` reflects it in the same cycle, and it is sampled at edge N+1.
- `alarm` rises one cycle after the qualified failure is observed.
- `block_valid` rises in the cycle after the 1024th write and holds until the handshake, or falls in the same cycle as a qualified failure.
- `block_ready` without `block_valid` has no effect.
- Reset mid-operation returns every register to its reset value at the next edge; any partial block is lost.

## Configuration
- `RNG_WARMUP_DISCARD_EN` defined:
  - Reset enters WARMUP.
  - The first WARMUP_BITS valid raw bits are counted and discarded; no writes and no overruns.
  - The state then moves to FILL.
- Not defined:
  - The WARMUP state and its counter are not compiled.
  - Reset enters FILL directly.

## Structure
- Shared package `rng_pkg`:
  - State enum `ebuf_state_t`.
  - Constants BUF_BITS, IDX_W, REP_WINDOW.
  - Overrun counter width.
- No sub-module. The repetition count test is instantiated beside this block at the RNG top, not inside it.

## Test plan
- Fill and handoff:
  - Stimulus: 1024 alternating 0/1 bits, `block_ready`=0.
  - Required: `block_valid`=1 with `index_of_last_bit`=1023.
  - Then: 5 extra bits give `overrun_cnt`=5, and the buffer is unchanged.
- Handshake and wrap:
  - Stimulus: pulse `block_ready`, then write 3 bits.
  - Required: `block_valid`=0 and `index_of_last_bit`=2; bits 0..2 are updated and bit 3 keeps its prior value.
- Early-history gating:
  - Stimulus: after reset, 21 zeros with `health_fail` forced to 1.
  - Required: `alarm` stays 0.
  - Then: the 22nd zero gives `alarm`=1 one cycle later, and the state is ALARM.
- Failure on a full block:
  - Stimulus: a full buffer with `block_valid`=1, then assert a qualified `health_fail`.
  - Required: `block_valid` drops in the same cycle and a concurrent `block_ready` does not complete.
  - Then: `alarm` stays 1 until `rst_n`=0.
- Warmup, with the macro defined:
  - Stimulus: 256 ones, then bit 0.
  - Required: `index_of_last_bit`=0, `random_bits`=0, and `fill_cnt`=1 after the 257th bit.
- Reset mid-fill:
  - Stimulus: 500 bits, then `rst_n`=0 for one cycle.
  - Required: all outputs return to their reset values, with `index_of_last_bit`=1023.

Source files
------------

// File: rtl/rng_pkg.sv
// rng_pkg: shared constants and state type for the entropy bit buffer.
// The WARMUP state exists only when RNG_WARMUP_DISCARD_EN is defined.
package rng_pkg;
    localparam int BUF_BITS    = 1024;
    localparam int IDX_W       = 10;
    localparam int CNT_W       = IDX_W + 1;
    localparam int REP_WINDOW  = 22;
    localparam int HIST_W      = 5;
    localparam int WARMUP_BITS = 256;
    localparam int WARM_W      = $clog2(WARMUP_BITS);
    localparam int OVR_W       = 16;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        ALARM = 2'd2
`ifdef RNG_WARMUP_DISCARD_EN
        , WARMUP = 2'd3
`endif
    } ebuf_state_t;
endpackage

// File: rtl/entropy_bit_buffer_if.sv
// entropy_bit_buffer_if: noise input, health feedback and conditioner handshake bundle.
interface entropy_bit_buffer_if;
    import rng_pkg::*;
    logic                raw_bit;
    logic                raw_valid;
    logic                health_fail;
    logic [BUF_BITS-1:0] random_bits;
    logic [IDX_W-1:0]    index_of_last_bit;
    logic                block_valid;
    logic                block_ready;
    logic                alarm;
    logic [OVR_W-1:0]    overrun_cnt;

    modport slave (
        input  raw_bit, raw_valid, health_fail, block_ready,
        output random_bits, index_of_last_bit, block_valid, alarm, overrun_cnt
    );
    modport master (
        output raw_bit, raw_valid, health_fail, block_ready,
        input  random_bits, index_of_last_bit, block_valid, alarm, overrun_cnt
    );
endinterface

// File: rtl/entropy_bit_buffer.sv
// entropy_bit_buffer: 1024-bit circular noise buffer with health gating and block handoff.
// Define RNG_WARMUP_DISCARD_EN to discard the first WARMUP_BITS raw bits after reset.
module entropy_bit_buffer
    import rng_pkg::*;
(
    input logic                  clk,
    input logic                  rst_n,
    entropy_bit_buffer_if.slave  bus
);
    ebuf_state_t         state, state_nxt;
    logic [BUF_BITS-1:0] bits_q;
    logic [IDX_W-1:0]    idx_q, idx_nxt;
    logic [CNT_W-1:0]    fill_cnt;
    logic [HIST_W-1:0]   hist_cnt;
    logic [OVR_W-1:0]    ovr_q;
    logic                alarm_q;
    logic                qual_fail, wr_en, ovr_en, hs, block_valid, last_fill;
`ifdef RNG_WARMUP_DISCARD_EN
    logic [WARM_W-1:0]   warm_cnt;
    logic                warm_done;
`endif

    always_comb begin
        qual_fail   = bus.health_fail && (hist_cnt == HIST_W'(REP_WINDOW))
                      && (state == FILL || state == FULL);
        block_valid = (state == FULL) && !qual_fail;
        hs          = block_valid && bus.block_ready;
        wr_en       = (state == FILL) && bus.raw_valid && !qual_fail;
        ovr_en      = (state == FULL) && bus.raw_valid && (ovr_q != '1);
        idx_nxt     = idx_q + 1'b1;
        last_fill   = fill_cnt == CNT_W'(BUF_BITS - 1);
`ifdef RNG_WARMUP_DISCARD_EN
        warm_done   = bus.raw_valid && (warm_cnt == WARM_W'(WARMUP_BITS - 1));
`endif
    end

    always_comb begin
        state_nxt = state;
        if (qual_fail)
            state_nxt = ALARM;
        else
            unique case (state)
                FILL:    state_nxt = (wr_en && last_fill) ? FULL : FILL;
                FULL:    state_nxt = hs ? FILL : FULL;
`ifdef RNG_WARMUP_DISCARD_EN
                WARMUP:  state_nxt = warm_done ? FILL : WARMUP;
`endif
                default: state_nxt = state;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef RNG_WARMUP_DISCARD_EN
            state    <= WARMUP;
            warm_cnt <= '0;
`else
            state    <= FILL;
`endif
            bits_q   <= '0;
            idx_q    <= '1;
            fill_cnt <= '0;
            hist_cnt <= '0;
            ovr_q    <= '0;
            alarm_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            alarm_q <= alarm_q | qual_fail;
            if (wr_en) begin
                bits_q[idx_nxt] <= bus.raw_bit;
                idx_q           <= idx_nxt;
                fill_cnt        <= fill_cnt + 1'b1;
                if (hist_cnt != HIST_W'(REP_WINDOW))
                    hist_cnt <= hist_cnt + 1'b1;
            end
            // history survives the handoff so the downstream window stays contiguous
            if (hs)
                fill_cnt <= '0;
            if (ovr_en)
                ovr_q <= ovr_q + 1'b1;
`ifdef RNG_WARMUP_DISCARD_EN
            if (state == WARMUP && bus.raw_valid)
                warm_cnt <= warm_cnt + 1'b1;
`endif
        end
    end

    assign bus.random_bits       = bits_q;
    assign bus.index_of_last_bit = idx_q;
    assign bus.block_valid       = block_valid;
    assign bus.alarm             = alarm_q;
    assign bus.overrun_cnt       = ovr_q;
endmodule
